rob_multi_commit: RTL
=====================

# rob_multi_commit

Parametrised reorder buffer for the commit stage. It accepts one in-order allocation per cycle from rename, and absorbs out-of-order writebacks from NUM_WB result buses. It retires up to COMMIT_W consecutive completed entries per cycle under a single commit handshake. A writeback-flagged misprediction or an external flush empties the buffer; the branch redirect target itself is delivered to the front end by the branch unit, not by this block.

## Interface
- DEPTH, 16, entry count; power of two, ≥4; TAG_W = $clog2(DEPTH)
- PAYLOAD_W, 32, opaque per-entry bits from rename (dest, freed reg, store flag, pc…), returned unchanged at commit
- RESULT_W, 16, writeback result width
- NUM_WB, 4, writeback ports
- COMMIT_W, 2, max retirements per cycle; 1 ≤ COMMIT_W ≤ DEPTH
- clk_i  in  1  clock; one clock
- reset_n_i  in  1  reset, synchronous, active-low
- alloc_valid_i  in  1  rename offers an entry
- alloc_payload_i  in  PAYLOAD_W  entry contents
- alloc_ready_o  out  1  entry accepted this cycle if alloc_valid_i also high
- alloc_tag_o  out  TAG_W  tag assigned to the offered entry (= tail pointer)
- wb_valid_i  in  NUM_WB  per-port writeback strobe
- wb_tag_i  in  NUM_WB*TAG_W  port p at [p*TAG_W +: TAG_W]
- wb_result_i  in  NUM_WB*RESULT_W  port p at [p*RESULT_W +: RESULT_W]
- wb_mispredict_i  in  NUM_WB  entry resolved as mispredicted branch
- commit_valid_o  out  COMMIT_W  lane k holds a retirable entry
- commit_payload_o  out  COMMIT_W*PAYLOAD_W  lane k payload
- commit_result_o  out  COMMIT_W*RESULT_W  lane k result
- commit_ready_i  in  1  consumer accepts all valid lanes this cycle
- flush_i  in  1  external flush (exception/debug)
- flush_o  out  1  misprediction flush taken this cycle
- count_o  out  TAG_W+1  occupied entries

## Operation
- State per entry: valid, wb, mispredict, payload, result. Pointers head, tail: TAG_W bits, wrap modulo DEPTH naturally. count: TAG_W+1 bits.
- Allocate: alloc_ready_o = (count != DEPTH) & ~flush_i & ~flush_o. On valid&ready: entry[tail] ← {valid=1, wb=0, mispredict=0, payload}; tail+1; count+1. No same-cycle bypass: when full, a commit in the same cycle does not enable allocation.
- Writeback: port p writes entry[tag] only if entry valid and wb=0 (registered state). It sets wb=1, result, and mispredict = wb_mispredict_i[p]. Writes to invalid or already-written entries are dropped. If several ports hit the same tag, the highest port index wins.
- Commit lanes: lane k is valid iff all of the following hold:
  - k < count;
  - entry[head+k] has valid & wb;
  - all lanes j<k are valid;
  - no lane j<k has mispredict=1.
- Commit lanes are combinational from registered state only; a writeback arriving this cycle cannot commit this cycle.
- Retire: when commit_ready_i=1, every valid lane retires. Retired entries clear valid/wb; head and count advance by the number of valid lanes. When commit_ready_i=0, state holds and lanes stay asserted.
- flush_o = commit_ready_i & (some valid lane has mispredict=1). That lane is the last valid lane; it retires normally.
- Flush (flush_o or flush_i): next state has all entries invalid, head=tail=0, count=0. In a flush cycle, allocation and all writebacks are dropped. flush_i does not retire lanes; any concurrent commit_valid_o is void.
- Allocation and commit in the same cycle: count changes by +1−n.

## Timing
- Reset (reset_n_i=0 at an edge) gives the same next state as a flush. The cycle after reset: alloc_ready_o=1, alloc_tag_o=0, commit_valid_o=0, flush_o=0, count_o=0. Reset asserted mid-operation discards all entries in one cycle.
- Minimum latency: allocate at edge N, writeback during cycle N+1, commit_valid_o high in cycle N+2.
- alloc_ready_o, commit_valid_o, flush_o and count_o depend only on registered state plus flush_i/commit_ready_i. They have no combinational path from alloc_valid_i or wb_*.
- Maximum throughput: 1 allocation and COMMIT_W retirements per cycle.

## Test plan
- Reset then fill: 16 allocations with alloc_valid_i held high → tags 0..15. The 17th is refused (alloc_ready_o=0), count_o=16. With no writebacks, commit_valid_o stays 0.
- Out-of-order completion, COMMIT_W=2: allocate tags 0–3; write back 3, 2, 1, then 0 on successive cycles. No lane is valid until tag 0 is written; then two cycles of lanes=2'b11 retire tags 0–3.
- Back-pressure: entries 0,1 complete with commit_ready_i=0 for 3 cycles → lanes held at 2'b11, count_o unchanged. Ready high → both retire in one cycle.
- Mispredict: tags 5,6,7 written, tag 5 with wb_mispredict_i=1 → only lane 0 valid. flush_o=1 with ready, allocation refused that cycle. Next cycle count_o=0, alloc_tag_o=0.
- Wrap and collisions: run 40 alloc/commit pairs so tail wraps twice, with payload integrity checked. Ports 0 and 3 write the same tag with results 0x1111/0x3333 → commit_result_o=0x3333. A write to an unallocated tag has no effect.
- flush_i while full with 2 completed at head → no retirement; next cycle empty and alloc_ready_o=1.

Source files
------------

// File: rtl/rob_multi_commit.sv
// Reorder buffer: in-order allocate, out-of-order writeback,
// up to COMMIT_W in-order retirements per cycle.
module rob_multi_commit #(
  parameter int DEPTH     = 16,
  parameter int PAYLOAD_W = 32,
  parameter int RESULT_W  = 16,
  parameter int NUM_WB    = 4,
  parameter int COMMIT_W  = 2,
  localparam int TAG_W    = $clog2(DEPTH)
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         alloc_valid_i,
  input  logic [PAYLOAD_W-1:0]         alloc_payload_i,
  output logic                         alloc_ready_o,
  output logic [TAG_W-1:0]             alloc_tag_o,
  input  logic [NUM_WB-1:0]            wb_valid_i,
  input  logic [NUM_WB*TAG_W-1:0]      wb_tag_i,
  input  logic [NUM_WB*RESULT_W-1:0]   wb_result_i,
  input  logic [NUM_WB-1:0]            wb_mispredict_i,
  output logic [COMMIT_W-1:0]          commit_valid_o,
  output logic [COMMIT_W*PAYLOAD_W-1:0] commit_payload_o,
  output logic [COMMIT_W*RESULT_W-1:0] commit_result_o,
  input  logic                         commit_ready_i,
  input  logic                         flush_i,
  output logic                         flush_o,
  output logic [TAG_W:0]               count_o
);

  logic [DEPTH-1:0]     ent_v;
  logic [DEPTH-1:0]     ent_wb;
  logic [DEPTH-1:0]     ent_mp;
  logic [PAYLOAD_W-1:0] ent_pay [DEPTH];
  logic [RESULT_W-1:0]  ent_res [DEPTH];

  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [TAG_W:0]   count;

  logic [TAG_W-1:0]    lane_idx [COMMIT_W];
  logic [COMMIT_W-1:0] lane_v;
  logic [COMMIT_W-1:0] lane_mp;
  logic [TAG_W:0]      n_ret;
  logic                blocked;

  logic [TAG_W-1:0]  wtag [NUM_WB];
  logic [NUM_WB-1:0] wb_hit;

  logic do_alloc;

  // Lanes stop after the first incomplete entry or after a mispredict.
  always_comb begin
    lane_v  = '0;
    lane_mp = '0;
    n_ret   = '0;
    blocked = 1'b0;
    for (int k = 0; k < COMMIT_W; k++) begin
      lane_idx[k] = head + TAG_W'(k);
      if (!blocked && ((TAG_W+1)'(k) < count) &&
          ent_v[lane_idx[k]] && ent_wb[lane_idx[k]]) begin
        lane_v[k]  = 1'b1;
        lane_mp[k] = ent_mp[lane_idx[k]];
        n_ret      = n_ret + (TAG_W+1)'(1);
        blocked    = ent_mp[lane_idx[k]];
      end else begin
        blocked = 1'b1;
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_WB; p++) begin
      wtag[p]   = wb_tag_i[p*TAG_W +: TAG_W];
      wb_hit[p] = wb_valid_i[p] & ent_v[wtag[p]] & ~ent_wb[wtag[p]];
    end
  end

  for (genvar k = 0; k < COMMIT_W; k++) begin : g_lane
    assign commit_payload_o[k*PAYLOAD_W +: PAYLOAD_W] =
      ent_pay[lane_idx[k]];
    assign commit_result_o[k*RESULT_W +: RESULT_W] =
      ent_res[lane_idx[k]];
  end

  assign commit_valid_o = lane_v;
  assign flush_o        = commit_ready_i & |lane_mp;
  assign alloc_ready_o  = (count != (TAG_W+1)'(DEPTH)) &
                          ~flush_i & ~flush_o;
  assign alloc_tag_o    = tail;
  assign count_o        = count;
  assign do_alloc       = alloc_valid_i & alloc_ready_o;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i || flush_i || flush_o) begin
      ent_v  <= '0;
      ent_wb <= '0;
      ent_mp <= '0;
      head   <= '0;
      tail   <= '0;
      count  <= '0;
    end else begin
      if (do_alloc) begin
        ent_v[tail]  <= 1'b1;
        ent_wb[tail] <= 1'b0;
        ent_mp[tail] <= 1'b0;
        tail         <= tail + TAG_W'(1);
      end
      // Later ports overwrite earlier ones on a shared tag.
      for (int p = 0; p < NUM_WB; p++) begin
        if (wb_hit[p]) begin
          ent_wb[wtag[p]] <= 1'b1;
          ent_mp[wtag[p]] <= wb_mispredict_i[p];
        end
      end
      if (commit_ready_i) begin
        for (int k = 0; k < COMMIT_W; k++) begin
          if (lane_v[k]) begin
            ent_v[lane_idx[k]]  <= 1'b0;
            ent_wb[lane_idx[k]] <= 1'b0;
          end
        end
      end
      head  <= head + (commit_ready_i ? n_ret[TAG_W-1:0] : '0);
      count <= count + (TAG_W+1)'(do_alloc) -
               (commit_ready_i ? n_ret : '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_alloc) ent_pay[tail] <= alloc_payload_i;
    for (int p = 0; p < NUM_WB; p++) begin
      if (wb_hit[p])
        ent_res[wtag[p]] <= wb_result_i[p*RESULT_W +: RESULT_W];
    end
  end

endmodule
